// File: rtl/line_buffer.sv
// line_buffer: two-bank scanline store. The renderer fills one bank while the other is read in step with the beam and erased behind it.
// Build option LINEBUF_PRIO_EN: the first non-zero write to a location wins, committed one clk_sys after wr_en.
module line_buffer #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int HSTART = 11,
  parameter int HTOTAL = 384,
  parameter int VTOTAL = 264
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          ce_pix,
  input  logic [8:0]    hcount,
  input  logic [8:0]    vcount,
  input  logic          hb,
  input  logic          vb,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_x,
  input  logic [DW-1:0] wr_data,
  output logic          line_start,
  output logic [8:0]    next_line,
  output logic [DW-1:0] pix_out,
  output logic          pix_de
);

  localparam int unsigned LINE_LEN = 1 << AW;
  localparam logic [8:0]  HSTART_9 = 9'(HSTART);
  localparam logic [8:0]  HLAST_9  = 9'(HTOTAL - 1);
  localparam logic [8:0]  VLAST_9  = 9'(VTOTAL - 1);

  // Bank contents are not reset; the warm-up count hides them until both banks have been erased once.
  logic [DW-1:0] mem [2][LINE_LEN];

  logic          wbank;
  logic [1:0]    swap_cnt;
  logic          warm;
  logic [8:0]    rx;
  logic          rx_ok;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          rd_edge;
  logic          swap_edge;

  logic          er_valid;
  logic          er_bank;
  logic [AW-1:0] er_addr;

  logic          s1_valid;
  logic          s1_de;
  logic [DW-1:0] s1_data;

  logic          wr_commit;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_val;

  assign rx        = hcount - HSTART_9;
  assign rx_ok     = (32'(rx) < LINE_LEN);
  assign raddr     = rx[AW-1:0];
  assign rdata     = mem[~wbank][raddr];
  assign rd_edge   = ce_pix && !hb;
  assign swap_edge = ce_pix && (hcount == HLAST_9);
  assign warm      = swap_cnt[1];

`ifdef LINEBUF_PRIO_EN
  logic          pw_valid;
  logic          pw_bank;
  logic [AW-1:0] pw_addr;
  logic [DW-1:0] pw_data;

  // The bank is checked on the commit edge, so an earlier commit to the same x is already visible.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pw_valid <= 1'b0;
      pw_bank  <= 1'b0;
      pw_addr  <= '0;
      pw_data  <= '0;
    end else begin
      pw_valid <= wr_en && (wr_data != '0);
      pw_bank  <= wbank;
      pw_addr  <= wr_x;
      pw_data  <= wr_data;
    end
  end

  assign wr_commit = pw_valid && (mem[pw_bank][pw_addr] == '0);
  assign wr_bank   = pw_bank;
  assign wr_addr   = pw_addr;
  assign wr_val    = pw_data;
`else
  assign wr_commit = wr_en && (wr_data != '0);
  assign wr_bank   = wbank;
  assign wr_addr   = wr_x;
  assign wr_val    = wr_data;
`endif

  // Renderer write is ordered after the erase so it wins if both ever hit one location.
  always_ff @(posedge clk_sys) begin
    if (er_valid) mem[er_bank][er_addr] <= '0;
    if (wr_commit) mem[wr_bank][wr_addr] <= wr_val;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wbank      <= 1'b0;
      swap_cnt   <= 2'd0;
      line_start <= 1'b0;
      next_line  <= '0;
      er_valid   <= 1'b0;
      er_bank    <= 1'b0;
      er_addr    <= '0;
      s1_valid   <= 1'b0;
      s1_de      <= 1'b0;
      s1_data    <= '0;
      pix_out    <= '0;
      pix_de     <= 1'b0;
    end else begin
      line_start <= 1'b0;
      er_valid   <= rd_edge && rx_ok;
      er_bank    <= ~wbank;
      er_addr    <= raddr;
      s1_valid   <= ce_pix;
      s1_de      <= !hb && !vb;
      s1_data    <= (rd_edge && rx_ok) ? rdata : '0;
      if (s1_valid) begin
        pix_de  <= s1_de;
        pix_out <= (s1_de && warm) ? s1_data : '0;
      end
      if (swap_edge) begin
        wbank      <= ~wbank;
        line_start <= 1'b1;
        next_line  <= (vcount == VLAST_9) ? 9'd0 : vcount + 9'd1;
        if (!warm) swap_cnt <= swap_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer: drives a beam timing generator and random/directed renderer writes, and checks
// every output each clock against an array-based model of the two banks.
`timescale 1ns/1ps
module tb_line_buffer;

  localparam int AW        = 8;
  localparam int DW        = 8;
  localparam int HSTART    = 11;
  localparam int HTOTAL    = 384;
  localparam int VTOTAL    = 264;
  localparam int LEN       = 1 << AW;
  localparam int HVIS_END  = HSTART + LEN;
  localparam int VIS_LINES = 240;
`ifdef LINEBUF_PRIO_EN
  localparam logic [DW-1:0] X5_EXP = 8'h07;
`else
  localparam logic [DW-1:0] X5_EXP = 8'h09;
`endif

  logic          clk_sys;
  logic          rst_n;
  logic          ce_pix;
  logic [8:0]    hcount;
  logic [8:0]    vcount;
  logic          hb;
  logic          vb;
  logic          wr_en;
  logic [AW-1:0] wr_x;
  logic [DW-1:0] wr_data;
  logic          line_start;
  logic [8:0]    next_line;
  logic [DW-1:0] pix_out;
  logic          pix_de;

  line_buffer #(
    .AW(AW), .DW(DW), .HSTART(HSTART), .HTOTAL(HTOTAL), .VTOTAL(VTOTAL)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount),
    .hb(hb), .vb(vb), .wr_en(wr_en), .wr_x(wr_x), .wr_data(wr_data),
    .line_start(line_start), .next_line(next_line), .pix_out(pix_out), .pix_de(pix_de)
  );

  // clock / reset
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // reference model and scoreboard
  logic [DW-1:0] mdl_bank [2][LEN];
  int            mdl_wb;
  int            mdl_swaps;
  bit            er_pend;
  int            er_bank;
  int            er_x;
  logic [DW:0]   exp_q[$];
  int            exp_x_q[$];
  logic [DW-1:0] exp_pix;
  logic          exp_de;
  logic          exp_ls;
  logic [8:0]    exp_nl;
  int            cur_x;

  // stimulus control
  logic [AW+DW-1:0] dir_q[$];
  bit               rand_wr;
  bit               swap_wr_en;
  logic [AW-1:0]    swap_wr_x;
  logic [DW-1:0]    swap_wr_d;
  bit               vjump_en;
  logic [8:0]       vjump;

  // observation
  int            n_cmp;
  int            n_bad;
  int            ls_count;
  int            nz_count;
  int            de_count;
  logic [DW-1:0] seen [LEN];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_wb    = 0;
    mdl_swaps = 0;
    er_pend   = 1'b0;
    exp_q.delete();
    exp_x_q.delete();
    exp_pix   = '0;
    exp_de    = 1'b0;
    exp_ls    = 1'b0;
    exp_nl    = '0;
  endtask

  // One clk_sys edge of the model, using the inputs that were presented to that edge.
  task automatic model_edge();
    int            rx;
    bit            rd;
    bit            de;
    logic [DW-1:0] v;
    logic [DW-1:0] o;
    logic [DW:0]   e;
    cur_x = -1;
    if (!rst_n) return;
    exp_ls = 1'b0;
    if (exp_q.size() > 0) begin
      e       = exp_q.pop_front();
      exp_de  = e[DW];
      exp_pix = e[DW-1:0];
      cur_x   = exp_x_q.pop_front();
    end
    if (er_pend) mdl_bank[er_bank][er_x] = '0;
    er_pend = 1'b0;
    if (wr_en && wr_data != '0) begin
`ifdef LINEBUF_PRIO_EN
      if (mdl_bank[mdl_wb][wr_x] == '0) mdl_bank[mdl_wb][wr_x] = wr_data;
`else
      mdl_bank[mdl_wb][wr_x] = wr_data;
`endif
    end
    if (ce_pix) begin
      rx = (int'(hcount) - HSTART + 512) % 512;
      rd = !hb && (rx < LEN);
      v  = rd ? mdl_bank[1 - mdl_wb][rx] : '0;
      if (rd) begin
        er_pend = 1'b1;
        er_bank = 1 - mdl_wb;
        er_x    = rx;
      end
      if (int'(hcount) == HTOTAL - 1) begin
        mdl_wb = 1 - mdl_wb;
        if (mdl_swaps < 2) mdl_swaps++;
        exp_ls = 1'b1;
        exp_nl = (int'(vcount) == VTOTAL - 1) ? 9'd0 : vcount + 9'd1;
      end
      de = !hb && !vb;
      o  = (de && mdl_swaps >= 2) ? v : '0;
      exp_q.push_back({de, o});
      exp_x_q.push_back((rd && de) ? rx : -1);
    end
  endtask

  // driver: timing generator plus renderer writes for the next edge
  task automatic drive_next();
    if (ce_pix) begin
      if (int'(hcount) == HTOTAL - 1) begin
        hcount = '0;
        if (vjump_en) begin
          vcount   = vjump;
          vjump_en = 1'b0;
        end else begin
          vcount = (int'(vcount) == VTOTAL - 1) ? 9'd0 : vcount + 9'd1;
        end
      end else begin
        hcount = hcount + 9'd1;
      end
      ce_pix = 1'b0;
    end else begin
      ce_pix = 1'b1;
    end
    hb      = (int'(hcount) < HSTART) || (int'(hcount) >= HVIS_END);
    vb      = int'(vcount) >= VIS_LINES;
    wr_en   = 1'b0;
    wr_x    = '0;
    wr_data = '0;
    if (swap_wr_en && ce_pix && int'(hcount) == HTOTAL - 1) begin
      wr_en      = 1'b1;
      wr_x       = swap_wr_x;
      wr_data    = swap_wr_d;
      swap_wr_en = 1'b0;
    end else if (dir_q.size() > 0) begin
      {wr_x, wr_data} = dir_q.pop_front();
      wr_en = 1'b1;
    end else if (rand_wr && rst_n && $urandom_range(0, 3) == 0) begin
      wr_en   = 1'b1;
      wr_x    = AW'($urandom_range(0, LEN - 1));
      wr_data = ($urandom_range(0, 4) == 0) ? 8'h00 : DW'($urandom_range(1, 255));
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_edge();
    #1;
    check("line_start", line_start, exp_ls);
    check("next_line", next_line, exp_nl);
    check("pix_out", pix_out, exp_pix);
    check("pix_de", pix_de, exp_de);
    if (line_start) ls_count++;
    if (pix_out != '0) nz_count++;
    if (pix_de) de_count++;
    if (cur_x >= 0) seen[cur_x] = pix_out;
    drive_next();
  endtask

  task automatic run_line();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2 * HTOTAL + 8 && !done; i++) begin
      step();
      done = exp_ls;
    end
    if (!done) check("line_timeout", 0, 1);
  endtask

  task automatic clear_obs();
    ls_count = 0;
    nz_count = 0;
    de_count = 0;
    for (int i = 0; i < LEN; i++) seen[i] = '0;
  endtask

  function automatic int seen_nz();
    int n;
    n = 0;
    for (int i = 0; i < LEN; i++) if (seen[i] != '0) n++;
    return n;
  endfunction

  logic [8:0] idle_nl [3];

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rand_wr    = 1'b0;
    swap_wr_en = 1'b0;
    vjump_en   = 1'b0;
    swap_wr_x  = '0;
    swap_wr_d  = '0;
    vjump      = '0;
    for (int b = 0; b < 2; b++) for (int i = 0; i < LEN; i++) mdl_bank[b][i] = '0;
    rst_n   = 1'b0;
    ce_pix  = 1'b0;
    hcount  = '0;
    vcount  = 9'd261;
    hb      = 1'b1;
    vb      = 1'b1;
    wr_en   = 1'b0;
    wr_x    = '0;
    wr_data = '0;
    model_reset();
    clear_obs();

    // reset state
    repeat (4) step();
    check("rst_line_start", line_start, 0);
    check("rst_next_line", next_line, 0);
    check("rst_pix_out", pix_out, 0);
    check("rst_pix_de", pix_de, 0);
    rst_n = 1'b1;

    // three idle lines across the frame wrap
    idle_nl[0] = 9'd262;
    idle_nl[1] = 9'd263;
    idle_nl[2] = 9'd0;
    for (int i = 0; i < 3; i++) begin
      clear_obs();
      run_line();
      check("idle_next_line", next_line, idle_nl[i]);
      check("idle_ls_count", ls_count, 1);
      check("idle_nonzero", nz_count, 0);
    end

    // line N: directed writes, including a same-x sequence
    dir_q.push_back({8'd0, 8'h12});
    dir_q.push_back({8'd239, 8'h34});
    dir_q.push_back({8'd5, 8'h07});
    dir_q.push_back({8'd5, 8'h09});
    dir_q.push_back({8'd5, 8'h00});
    run_line();

    // line N+1: display them; write on its closing swap edge
    swap_wr_en = 1'b1;
    swap_wr_x  = 8'd3;
    swap_wr_d  = 8'h55;
    clear_obs();
    run_line();
    check("disp_x0", seen[0], 8'h12);
    check("disp_x239", seen[239], 8'h34);
    check("disp_x5", seen[5], X5_EXP);
    check("disp_nz_count", seen_nz(), 3);
    check("vis_de_count", de_count, 2 * LEN);

    // line N+2: only the swap-edge write remains
    vjump_en = 1'b1;
    vjump    = 9'd240;
    clear_obs();
    run_line();
    check("swapwr_x3", seen[3], 8'h55);
    check("erased_x0", seen[0], 8'h00);
    check("swapwr_nz_count", seen_nz(), 1);

    // blanking: write during vb, read-out blanked but still erased
    dir_q.push_back({8'd10, 8'h66});
    run_line();
    vjump_en = 1'b1;
    vjump    = 9'd263;
    clear_obs();
    run_line();
    check("vb_de_count", de_count, 0);
    check("vb_nonzero", nz_count, 0);
    run_line();
    check("wrap_next_line", next_line, 0);
    clear_obs();
    run_line();
    check("vb_erased_x10", seen[10], 8'h00);

    // random writes
    rand_wr = 1'b1;
    repeat (6) run_line();

    // mid-line reset with visible data
    rand_wr = 1'b0;
    for (int i = 85; i <= 95; i++) dir_q.push_back({8'(i), 8'h3C});
    run_line();
    for (int i = 0; i < 2 * HTOTAL && int'(hcount) != 100; i++) step();
    check("pre_rst_pix", pix_out, 8'h3C);
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_pix_out", pix_out, 0);
    check("async_pix_de", pix_de, 0);
    check("async_line_start", line_start, 0);
    check("async_next_line", next_line, 0);
    repeat (3) step();
    rst_n   = 1'b1;
    rand_wr = 1'b1;
    clear_obs();
    run_line();
    check("post_rst_ls_count", ls_count, 1);
    run_line();
    check("warmup_nonzero", nz_count, 0);
    repeat (3) run_line();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
